// File: rtl/display7_pkg.sv
// Shared constants for the display7 scan driver: the segment-off pattern,
// the hex decode table and the parameter range checks.
package display7_pkg;

  // All segments dark (the pins are active-low).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-high segment patterns {g,f,e,d,c,b,a}, indexed by hex nibble.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Legal digit count range.
  localparam int N_DIGITS_MIN = 1;
  localparam int N_DIGITS_MAX = 8;

  // True when the scan parameters describe a usable display.
  function automatic bit params_ok(int n_digits, int scan_div, int blank_cyc);
    return (n_digits >= N_DIGITS_MIN) && (n_digits <= N_DIGITS_MAX) &&
           (blank_cyc >= 0) && (scan_div > blank_cyc);
  endfunction

endpackage

// File: rtl/display7_if.sv
// Data/load inputs and pin outputs of the display7 scan driver.
// master = the side producing value/digit_en/load, slave = the driver.
interface display7_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   digit_en;
  logic                  load;
  logic [6:0]            seg;
  logic [N_DIGITS-1:0]   an;
  logic                  frame_tick;

  modport master (output value, digit_en, load, input seg, an, frame_tick);
  modport slave  (input value, digit_en, load, output seg, an, frame_tick);
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decode
  import display7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = ~HEX_SEG[nibble];

endmodule

// File: rtl/display7_scan.sv
// Time-multiplexed driver for N common-anode 7-segment digits.
// New data is staged in a pending register and copied to the displayed
// (active) register only at the frame wrap, so a frame never tears.
// Optional feature macro: DISPLAY7_LZB_EN (leading-zero blanking).
module display7_scan
  import display7_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 27000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  display7_if.slave  bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
  localparam bit CFG_OK = params_ok(N_DIGITS, SCAN_DIV, BLANK_CYC);

  if (!CFG_OK) begin : g_bad_cfg
    $error("display7_scan: need 1<=N_DIGITS<=8 and SCAN_DIV>BLANK_CYC");
  end

  logic [DIV_W-1:0]      div_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [4*N_DIGITS-1:0] pend_value_reg, act_value_reg;
  logic [N_DIGITS-1:0]   pend_en_reg, act_en_reg;
  logic [6:0]            seg_reg;
  logic [N_DIGITS-1:0]   an_reg;
  logic                  tick_reg;

  logic                  slot_end, boundary, lit, digit_shown;
  logic [4*N_DIGITS-1:0] value_next;
  logic [N_DIGITS-1:0]   en_next, an_next;
  logic [N_DIGITS-1:0][3:0] act_nibbles;
  logic [3:0]            nibble;
  logic [6:0]            dec_seg, seg_next;

  assign slot_end = (div_reg == DIV_LAST);
  assign boundary = slot_end && (idx_reg == IDX_LAST);
  assign lit      = (div_reg >= BLANK_END);

  // A load on any cycle wins over the held pending data; on the boundary
  // this same value goes straight into the active register.
  assign value_next = bus.load ? bus.value    : pend_value_reg;
  assign en_next    = bus.load ? bus.digit_en : pend_en_reg;

  assign act_nibbles = act_value_reg;
  assign nibble      = act_nibbles[idx_reg];

  seg7_hex_decode u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

`ifdef DISPLAY7_LZB_EN
  logic [N_DIGITS-1:0] lzb_next, lzb_mask_reg;

  // Digit k stays visible if it or any higher nibble is nonzero; digit 0 always.
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_lzb
    if (gi == 0) begin : g_d0
      assign lzb_next[gi] = 1'b1;
    end else begin : g_dk
      assign lzb_next[gi] = |value_next[4*N_DIGITS-1:4*gi];
    end
  end

  // Blanking mask follows the active register, updated at the same wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lzb_mask_reg <= N_DIGITS'(1);
    end else if (boundary) begin
      lzb_mask_reg <= lzb_next;
    end
  end

  assign digit_shown = act_en_reg[idx_reg] & lzb_mask_reg[idx_reg];
`else
  assign digit_shown = act_en_reg[idx_reg];
`endif

  assign seg_next = (lit && digit_shown) ? dec_seg : SEG_OFF;

  // Only the current digit's anode goes low, and only outside the blank window.
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_an
    assign an_next[gi] = !(lit && (idx_reg == IDX_W'(gi)));
  end

  // Slot divider and digit index; the index advances at each slot end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= '0;
      idx_reg <= '0;
    end else if (slot_end) begin
      div_reg <= '0;
      idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

  // Pending captures every load; active takes pending (or the bypassed load) at the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_value_reg <= '0;
      pend_en_reg    <= '0;
      act_value_reg  <= '0;
      act_en_reg     <= '0;
    end else begin
      pend_value_reg <= value_next;
      pend_en_reg    <= en_next;
      if (boundary) begin
        act_value_reg <= value_next;
        act_en_reg    <= en_next;
      end
    end
  end

  // Registered pin drivers and frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_reg  <= SEG_OFF;
      an_reg   <= '1;
      tick_reg <= 1'b0;
    end else begin
      seg_reg  <= seg_next;
      an_reg   <= an_next;
      tick_reg <= boundary;
    end
  end

  assign bus.seg        = seg_reg;
  assign bus.an         = an_reg;
  assign bus.frame_tick = tick_reg;

endmodule
